uart_tx_arb: RTL and testbench

Round-robin scheduler that shares one `uart_tx` transmitter between `NCH` byte requesters. Each requester owns a one-byte holding register. The arbiter picks a full register, presents the byte on the `uart_tx` valid/ready port and holds it until the transmitter has taken it. The block sits between the command/status sources and `uart_tx`, entirely in the system `clk` domain.

---
 rtl/uart_tx_arb.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Round-robin scheduler sharing one uart_tx among NCH one-byte
//            holding registers. Define UART_TX_ARB_LOCK_EN to keep packets
//            (delimited by req_last) contiguous on the line.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arb #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int IDW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  input  logic [NCH-1:0]    req_last,
  output logic [NCH-1:0]    req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_OFFER = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_rdy_meta;
  logic                   r_rdy_s;
  logic [NCH-1:0]         r_full;
  logic [NCH-1:0][DW-1:0] r_data;
  logic [IDW-1:0]         r_ptr;
  logic [NCH-1:0]         w_elig;
  logic                   w_found;
  logic [IDW-1:0]         w_win;
  logic [IDW-1:0]         w_cand;
  logic                   w_take;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NCH-1:0]         r_last;
  logic                   r_last_q;
  logic                   r_lock;
`else
  logic                   w_unused_last;
  assign w_unused_last = ^req_last;
`endif

  assign req_ready = ~r_full;
  assign w_take    = (r_state == S_ARB) && w_found && r_rdy_s;

  // tx_ready comes from the uart_tx bit-rate logic; treat it as asynchronous
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_meta <= 1'b1;
      r_rdy_s    <= 1'b1;
    end else begin
      r_rdy_meta <= tx_ready;
      r_rdy_s    <= r_rdy_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= '0;
      r_data <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      r_last <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_take && (w_win == IDW'(i))) begin
          r_full[i] <= 1'b0;
        end else if (req_valid[i] && !r_full[i]) begin
          r_full[i] <= 1'b1;
          r_data[i] <= req_data[i*DW +: DW];
`ifdef UART_TX_ARB_LOCK_EN
          r_last[i] <= req_last[i];
`endif
        end
      end
    end
  end

  always_comb begin
`ifdef UART_TX_ARB_LOCK_EN
    w_elig = r_lock ? (r_full & ({{(NCH-1){1'b0}}, 1'b1} << grant_id)) : r_full;
`else
    w_elig = r_full;
`endif
  end

  // Search downward so the candidate closest to ptr+1 is assigned last and wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_cand = IDW'((int'(r_ptr) + k) % NCH);
      if (w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      r_ptr    <= IDW'(NCH-1);
`ifdef UART_TX_ARB_LOCK_EN
      r_last_q <= 1'b0;
      r_lock   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((|r_full) && r_rdy_s) begin
            r_state <= S_ARB;
            busy    <= 1'b1;
          end
        end
        S_ARB: begin
          if (w_take) begin
            tx_data  <= r_data[w_win];
            grant_id <= w_win;
            r_ptr    <= w_win;
            tx_valid <= 1'b1;
            r_state  <= S_OFFER;
`ifdef UART_TX_ARB_LOCK_EN
            r_last_q <= r_last[w_win];
`endif
          end
        end
        S_OFFER: begin
          // uart_tx drops ready once it has taken the byte
          if (!r_rdy_s) begin
            tx_valid <= 1'b0;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_rdy_s) begin
`ifdef UART_TX_ARB_LOCK_EN
            r_lock <= ~r_last_q;
`endif
            if (|r_full) begin
              r_state <= S_ARB;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arb
// Brief    : Directed bench for uart_tx_arb with a byte feeder per channel and
//            a simple uart_tx ready model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arb;

  localparam int NCH   = 4;
  localparam int FRAME = 6;

  logic           clk;
  logic           rst;
  logic [3:0]     req_valid;
  logic [31:0]    req_data;
  logic [3:0]     req_last;
  logic [3:0]     req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [1:0]     grant_id;
  logic           busy;

  logic           model_en;
  logic           model_rdy;
  logic           man_rdy;
  int             model_cnt;
  logic [3:0]     prev_ready;
  logic [8:0]     fq [NCH][$];
  logic [1:0]     log_id [$];
  logic [7:0]     log_data [$];

  int checks;
  int failures;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic [1:0] exp_id;
    logic [7:0] exp_data;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs [4];

  assign tx_ready = model_en ? model_rdy : man_rdy;

  uart_tx_arb #(.NCH(4), .DW(8), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Feeder: presents the head of each channel queue, pops it once captured
  initial begin
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    prev_ready = '1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (req_valid[i] && prev_ready[i] && fq[i].size() > 0)
          void'(fq[i].pop_front());
        prev_ready[i] = req_ready[i];
        if (fq[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_data[i*8 +: 8]    = fq[i][0][7:0];
          req_last[i]           = fq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // uart_tx model: takes a byte when ready, stays busy for FRAME cycles
  initial begin
    model_rdy = 1'b1;
    model_cnt = 0;
    forever begin
      @(negedge clk);
      if (model_en) begin
        if (model_rdy && tx_valid) begin
          log_id.push_back(grant_id);
          log_data.push_back(tx_data);
          model_rdy = 1'b0;
          model_cnt = FRAME;
        end else if (!model_rdy) begin
          if (model_cnt > 0) model_cnt--;
          if (model_cnt == 0) model_rdy = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic last, input logic [7:0] d);
    fq[ch].push_back({last, d});
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, {31'd0, tx_valid}, 32'd1);
  endtask

  // Manual transmitter acceptance; also checks the 3-cycle release
  task automatic handshake(input string nm);
    @(negedge clk);
    man_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(nm, {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    man_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input string nm);
    int c;
    c = 0;
    while (log_id.size() < n && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    chk(nm, log_id.size(), n);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (!(busy == 1'b0 && model_rdy == 1'b1 && tx_valid == 1'b0) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0] exp_id4 [4];
    logic [7:0] exp_d4 [4];
    int         hi;

    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    man_rdy   = 1'b1;
    model_en  = 1'b0;

    vecs[0] = '{2, 8'hA5, 2'd2, 8'hA5, 4'b1011};
    vecs[1] = '{0, 8'h3C, 2'd0, 8'h3C, 4'b1110};
    vecs[2] = '{3, 8'hFF, 2'd3, 8'hFF, 4'b0111};
    vecs[3] = '{1, 8'h00, 2'd1, 8'h00, 4'b1101};

`ifdef UART_TX_ARB_LOCK_EN
    exp_id4 = '{2'd0, 2'd0, 2'd0, 2'd1};
    exp_d4  = '{8'hA1, 8'hA2, 8'hA3, 8'hB1};
`else
    exp_id4 = '{2'd0, 2'd1, 2'd0, 2'd0};
    exp_d4  = '{8'hA1, 8'hB1, 8'hA2, 8'hA3};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'hF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single-byte transfers from the vector table
    for (int v = 0; v < 4; v++) begin
      push(vecs[v].ch, 1'b1, vecs[v].data);
      @(posedge clk); #1;
      chk("sb_ready_held", {28'd0, req_ready}, {28'd0, vecs[v].exp_ready});
      chk("sb_valid_early", {31'd0, tx_valid}, 32'd0);
      @(posedge clk); #1;
      chk("sb_busy_arb", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("sb_valid", {31'd0, tx_valid}, 32'd1);
      chk("sb_data", {24'd0, tx_data}, {24'd0, vecs[v].exp_data});
      chk("sb_grant", {30'd0, grant_id}, {30'd0, vecs[v].exp_id});
      chk("sb_ready_free", {28'd0, req_ready}, 32'hF);
      @(negedge clk);
      man_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("sb_valid_hold", {31'd0, tx_valid}, 32'd1);
      @(posedge clk); #1;
      chk("sb_release", {31'd0, tx_valid}, 32'd0);
      @(negedge clk);
      man_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("sb_idle", {31'd0, busy}, 32'd0);
    end

    // Busy transmitter: ch3 waits until tx_ready returns
    @(negedge clk);
    man_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(3, 1'b1, 8'h5A);
    hi = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (tx_valid) hi++;
    end
    chk("bt_no_valid", hi, 0);
    chk("bt_ch3_full", {31'd0, req_ready[3]}, 32'd0);
    chk("bt_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    man_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bt_valid_wait", {31'd0, tx_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bt_valid", {31'd0, tx_valid}, 32'd1);
    chk("bt_grant", {30'd0, grant_id}, 32'd3);
    chk("bt_data", {24'd0, tx_data}, 32'h5A);
    handshake("bt_release");

    // Backpressure on ch1
    push(1, 1'b1, 8'h11);
    push(1, 1'b1, 8'h22);
    @(posedge clk); #1;
    chk("bp_ready_n", {31'd0, req_ready[1]}, 32'd0);
    @(posedge clk); #1;
    chk("bp_ready_n1", {31'd0, req_ready[1]}, 32'd0);
    @(posedge clk); #1;
    chk("bp_ready_free", {31'd0, req_ready[1]}, 32'd1);
    chk("bp_data1", {24'd0, tx_data}, 32'h11);
    @(posedge clk); #1;
    chk("bp_ready_recap", {31'd0, req_ready[1]}, 32'd0);
    handshake("bp_release1");
    wait_valid("bp_valid2");
    chk("bp_data2", {24'd0, tx_data}, 32'h22);
    handshake("bp_release2");

    // Fairness: all channels keep a byte pending
    do_reset();
    model_en = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NCH; c++)
        push(c, 1'b1, 8'(c * 16 + i));
    wait_log(12, "fair_count");
    for (int k = 0; k < 12 && k < log_id.size(); k++) begin
      chk("fair_order", {30'd0, log_id[k]}, k % 4);
      chk("fair_data", {24'd0, log_data[k]}, (k % 4) * 16 + k / 4);
    end
    wait_idle("fair_idle");
    model_en = 1'b0;

    // Packet of three bytes on ch0 with ch1 pending
    do_reset();
    log_id.delete();
    log_data.delete();
    model_en = 1'b1;
    push(0, 1'b0, 8'hA1);
    push(0, 1'b0, 8'hA2);
    push(0, 1'b1, 8'hA3);
    push(1, 1'b1, 8'hB1);
    wait_log(4, "pkt_count");
    for (int k = 0; k < 4 && k < log_id.size(); k++) begin
      chk("pkt_order", {30'd0, log_id[k]}, {30'd0, exp_id4[k]});
      chk("pkt_data", {24'd0, log_data[k]}, {24'd0, exp_d4[k]});
    end
    wait_idle("pkt_idle");
    model_en = 1'b0;

    // Reset in the middle of OFFER with another byte pending
    push(1, 1'b1, 8'hC1);
    @(posedge clk); #1;
    wait_valid("mr_valid");
    push(3, 1'b1, 8'hC3);
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    chk("mr_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mr_req_ready", {28'd0, req_ready}, 32'hF);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_grant", {30'd0, grant_id}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    push(0, 1'b1, 8'hD0);
    push(2, 1'b1, 8'hD2);
    @(posedge clk); #1;
    wait_valid("mr_valid_a");
    chk("mr_first_grant", {30'd0, grant_id}, 32'd0);
    chk("mr_first_data", {24'd0, tx_data}, 32'hD0);
    handshake("mr_release_a");
    wait_valid("mr_valid_b");
    chk("mr_second_grant", {30'd0, grant_id}, 32'd2);
    chk("mr_second_data", {24'd0, tx_data}, 32'hD2);
    handshake("mr_release_b");
    hi = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tx_valid || busy) hi++;
    end
    chk("mr_dropped", hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
